// File: rtl/uart_pkg.sv
// Shared UART definitions for the transmit and receive paths.
package uart_pkg;
  localparam int UART_DATA_W      = 8;
  localparam int UART_CLK_FREQ_HZ = 6_250_000;
  localparam int UART_BAUD_RATE   = 230400;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO in front of the UART shifter; show-ahead read, push and pop may coincide even when full.
// Depth must be a power of two, at least 2.
module uart_tx_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  // A push into a full FIFO is fine when the same edge frees a slot.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter, LSB first, one frame at a time over a valid/ready handshake.
// Define UART_TX_FIFO_EN to put a FIFO_DEPTH-entry byte FIFO in front for back-to-back streaming.
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ = UART_CLK_FREQ_HZ,
  parameter int BAUD_RATE   = UART_BAUD_RATE,
  parameter int STOP_BITS   = 1,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [UART_DATA_W-1:0] tx_data,
  input  logic                   tx_valid,
  output logic                   tx_ready,
  output logic                   TxD,
  output logic                   tx_busy,
  output logic                   tx_done
);
  localparam int BIT_CYCLES  = CLK_FREQ_HZ / BAUD_RATE;
  localparam int STOP_CYCLES = STOP_BITS * BIT_CYCLES;
  localparam int CW          = $clog2(STOP_CYCLES);

  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $error("uart_transmitter: STOP_BITS must be 1 or 2");
  end

  tx_state_t              state;
  logic [UART_DATA_W-1:0] shift;
  logic [2:0]             bit_idx;
  logic [CW-1:0]          cyc;
  logic                   bit_end, stop_end;
  logic                   idle_load, stop_load;
  logic [UART_DATA_W-1:0] load_dat;

  assign bit_end  = (cyc == CW'(BIT_CYCLES - 1));
  assign stop_end = (cyc == CW'(STOP_CYCLES - 1));

`ifdef UART_TX_FIFO_EN
  logic                      fifo_full, fifo_empty, fifo_pop;
  logic [$clog2(FIFO_DEPTH):0] fifo_cnt;

  // Popping on the last stop cycle chains straight into the next start bit.
  assign idle_load = (state == IDLE) && !fifo_empty;
  assign stop_load = (state == STOP) && stop_end && !fifo_empty;
  assign fifo_pop  = idle_load || stop_load;
  assign tx_ready  = !fifo_full;
  assign tx_busy   = (state != IDLE) || (fifo_cnt != '0);

  uart_tx_fifo #(.DEPTH(FIFO_DEPTH), .W(UART_DATA_W)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (tx_valid && !fifo_full),
    .din   (tx_data),
    .pop   (fifo_pop),
    .dout  (load_dat),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );
`else
  assign idle_load = (state == IDLE) && tx_valid;
  assign stop_load = 1'b0;
  assign load_dat  = tx_data;
  assign tx_ready  = (state == IDLE);
  assign tx_busy   = (state != IDLE);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      TxD     <= 1'b1;
      tx_done <= 1'b0;
      shift   <= '0;
      bit_idx <= '0;
      cyc     <= '0;
    end else begin
      tx_done <= 1'b0;
      case (state)
        IDLE: begin
          TxD <= 1'b1;
          cyc <= '0;
          if (idle_load) begin
            shift <= load_dat;
            state <= START;
            TxD   <= 1'b0;
          end
        end
        START: begin
          if (bit_end) begin
            cyc     <= '0;
            bit_idx <= '0;
            state   <= DATA;
            TxD     <= shift[0];
          end else begin
            cyc <= cyc + CW'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            cyc   <= '0;
            shift <= {1'b0, shift[UART_DATA_W-1:1]};
            if (bit_idx == 3'(UART_DATA_W - 1)) begin
              state <= STOP;
              TxD   <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              TxD     <= shift[1];
            end
          end else begin
            cyc <= cyc + CW'(1);
          end
        end
        STOP: begin
          if (stop_end) begin
            cyc     <= '0;
            tx_done <= 1'b1;
            if (stop_load) begin
              shift <= load_dat;
              state <= START;
              TxD   <= 1'b0;
            end else begin
              state <= IDLE;
              TxD   <= 1'b1;
            end
          end else begin
            cyc <= cyc + CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          TxD   <= 1'b1;
        end
      endcase
    end
  end
endmodule
